apu_frame_counter: RTL and testbench

//  Frame sequencer ($4017) for the PAPU. Counts CPU clocks and emits 1-cycle

---
 rtl/apu_frame_counter_if.sv | 20 ++
 rtl/apu_frame_counter.sv | 124 ++++++++++++
 tb/tb_apu_frame_counter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_frame_counter_if.sv
// Register-write side and channel-strobe side of the APU frame sequencer.
interface apu_frame_counter_if;
    logic       r4017_wr;
    logic [7:0] r4017_data;
    logic       r4015_rd;
    logic       apu_tick;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;

    modport master (
        output r4017_wr, r4017_data, r4015_rd,
        input  apu_tick, quarter_frame, half_frame, frame_irq
    );

    modport slave (
        input  r4017_wr, r4017_data, r4015_rd,
        output apu_tick, quarter_frame, half_frame, frame_irq
    );
endinterface

// File: rtl/apu_frame_counter.sv
// APU frame sequencer ($4017): counts CPU clocks, emits quarter/half-frame
// strobes and the APU tick, and raises the frame IRQ in 4-step mode.
module apu_frame_counter #(
    parameter int CNT_W = 16,
    parameter int S1    = 7457,
    parameter int S2    = 14913,
    parameter int S3    = 22371,
    parameter int S4    = 29829,
    parameter int S5    = 37281
) (
    input  logic               clk,
    input  logic               rst_n,
    apu_frame_counter_if.slave bus
);
    localparam logic [CNT_W-1:0] C_S1   = CNT_W'(S1);
    localparam logic [CNT_W-1:0] C_S2   = CNT_W'(S2);
    localparam logic [CNT_W-1:0] C_S3   = CNT_W'(S3);
    localparam logic [CNT_W-1:0] C_S4   = CNT_W'(S4);
    localparam logic [CNT_W-1:0] C_S5   = CNT_W'(S5);
    localparam logic [CNT_W-1:0] C_S4M1 = CNT_W'(S4 - 1);
    localparam logic [CNT_W-1:0] C_S4P1 = CNT_W'(S4 + 1);
    localparam logic [CNT_W-1:0] C_S5P1 = CNT_W'(S5 + 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             mode;
    logic             irq_inhibit;
    logic             pending;
    logic [1:0]       dly;
    logic             tick_q;
    logic             quarter_q;
    logic             half_q;
    logic             irq_q;

    logic             step_q;
    logic             step_h;
    logic             irq_set;
    logic             wrap;
    logic             force_zero;
    logic             wr_imm;
    logic             unused_data;

    assign unused_data = ^bus.r4017_data[5:0];

    // Step/IRQ decode on the current count, using the mode already latched.
    always_comb begin
        step_q = 1'b0;
        step_h = 1'b0;
        if (cnt == C_S1 || cnt == C_S3) begin
            step_q = 1'b1;
        end
        if (cnt == C_S2) begin
            step_q = 1'b1;
            step_h = 1'b1;
        end
        if (!mode && cnt == C_S4) begin
            step_q = 1'b1;
            step_h = 1'b1;
        end
        if (mode && cnt == C_S5) begin
            step_q = 1'b1;
            step_h = 1'b1;
        end
        irq_set    = !mode && !irq_inhibit &&
                     (cnt == C_S4M1 || cnt == C_S4 || cnt == C_S4P1);
        wrap       = mode ? (cnt == C_S5P1) : (cnt == C_S4P1);
        // A fresh write restarts the delay, so it cancels an expiring one.
        force_zero = pending && (dly == 2'd0) && !bus.r4017_wr;
        wr_imm     = bus.r4017_wr && bus.r4017_data[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            phase       <= 1'b0;
            mode        <= 1'b0;
            irq_inhibit <= 1'b0;
            pending     <= 1'b0;
            dly         <= 2'd0;
            tick_q      <= 1'b0;
            quarter_q   <= 1'b0;
            half_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            phase     <= ~phase;
            tick_q    <= ~phase;
            quarter_q <= step_q || wr_imm;
            half_q    <= step_h || wr_imm;

            if (force_zero || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Remaining edges before the forced reset: D-1, i.e. 2 or 3.
            if (bus.r4017_wr) begin
                mode        <= bus.r4017_data[7];
                irq_inhibit <= bus.r4017_data[6];
                pending     <= 1'b1;
                dly         <= phase ? 2'd3 : 2'd2;
            end else if (pending) begin
                if (dly == 2'd0) begin
                    pending <= 1'b0;
                end else begin
                    dly <= dly - 2'd1;
                end
            end

            if (bus.r4017_wr && bus.r4017_data[6]) begin
                irq_q <= 1'b0;
            end else if (irq_set) begin
                irq_q <= 1'b1;
            end else if (bus.r4015_rd) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign bus.apu_tick      = tick_q;
    assign bus.quarter_frame = quarter_q;
    assign bus.half_frame    = half_q;
    assign bus.frame_irq     = irq_q;
endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench: a full-size sequencer for the nominal timing and a
// shortened one for multi-sequence mode, inhibit, restart and reset cases.
module tb_apu_frame_counter;
    localparam int S1 = 7457;
    localparam int S2 = 14913;
    localparam int S3 = 22371;
    localparam int S4 = 29829;
    localparam int S5 = 37281;

    localparam int SS1 = 20;
    localparam int SS2 = 41;
    localparam int SS3 = 62;
    localparam int SS4 = 83;
    localparam int SS5 = 104;

    logic clk;
    logic rst_n;
    logic rst_s_n;

    int errors = 0;
    int checks = 0;

    int bcyc;
    int scyc;
    int bq[$];
    int bh[$];
    int sq[$];
    int sh[$];
    int b_irq_first;
    int s_irq_hi;

    apu_frame_counter_if bif ();
    apu_frame_counter_if sif ();

    apu_frame_counter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    apu_frame_counter #(
        .CNT_W (8),
        .S1    (SS1),
        .S2    (SS2),
        .S3    (SS3),
        .S4    (SS4),
        .S5    (SS5)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_s_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string qstr(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic run_big(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bcyc++;
            if (bif.quarter_frame) bq.push_back(bcyc);
            if (bif.half_frame) bh.push_back(bcyc);
            if (bif.frame_irq && b_irq_first < 0) b_irq_first = bcyc;
        end
    endtask

    task automatic run_small(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            scyc++;
            if (sif.quarter_frame) sq.push_back(scyc);
            if (sif.half_frame) sh.push_back(scyc);
            if (sif.frame_irq) s_irq_hi++;
        end
    endtask

    task automatic restart_small();
        rst_s_n = 1'b0;
        tick();
        rst_s_n = 1'b1;
        scyc = 0;
        sq.delete();
        sh.delete();
        s_irq_hi = 0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bif.apu_tick, bif.quarter_frame, bif.half_frame, bif.frame_irq} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {bif.apu_tick, bif.quarter_frame, bif.half_frame, bif.frame_irq});
        end
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        bcyc = 0;
        scyc = 0;
    endtask

    task automatic test_mode0_sequence();
        int eq[$];
        bq.delete();
        bh.delete();
        b_irq_first = -1;
        run_big(S4 - 1);
        eq = '{S1 + 1, S2 + 1, S3 + 1};
        checks++;
        if (qstr(bq) != qstr(eq)) begin
            errors++;
            $display("FAIL mode0_quarter got=[%s] exp=[%s]", qstr(bq), qstr(eq));
        end
        eq = '{S2 + 1};
        checks++;
        if (qstr(bh) != qstr(eq)) begin
            errors++;
            $display("FAIL mode0_half got=[%s] exp=[%s]", qstr(bh), qstr(eq));
        end
        checks++;
        if (b_irq_first != -1) begin
            errors++;
            $display("FAIL irq_early got=%0d exp=-1", b_irq_first);
        end
        checks++;
        if (bif.apu_tick !== 1'b0) begin
            errors++;
            $display("FAIL apu_tick_even got=%b exp=0", bif.apu_tick);
        end
    endtask

    task automatic test_irq_read();
        int eq[$];
        bq.delete();
        bh.delete();
        run_big(1);
        checks++;
        if (b_irq_first != S4) begin
            errors++;
            $display("FAIL irq_rise got=%0d exp=%0d", b_irq_first, S4);
        end
        checks++;
        if (bif.apu_tick !== 1'b1) begin
            errors++;
            $display("FAIL apu_tick_odd got=%b exp=1", bif.apu_tick);
        end
        bif.r4015_rd = 1'b1;
        run_big(1);
        bif.r4015_rd = 1'b0;
        checks++;
        if (bif.frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_read_at_s4 got=%b exp=1", bif.frame_irq);
        end
        run_big(S4 + 100 - bcyc);
        checks++;
        if (bif.frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_level_hold got=%b exp=1", bif.frame_irq);
        end
        bif.r4015_rd = 1'b1;
        run_big(1);
        bif.r4015_rd = 1'b0;
        checks++;
        if (bif.frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_read_clear got=%b exp=0", bif.frame_irq);
        end
        run_big(S4 + 2 + S1 + 1 - bcyc);
        eq = '{S4 + 1, S4 + 2 + S1 + 1};
        checks++;
        if (qstr(bq) != qstr(eq)) begin
            errors++;
            $display("FAIL mode0_wrap_quarter got=[%s] exp=[%s]", qstr(bq), qstr(eq));
        end
        eq = '{S4 + 1};
        checks++;
        if (qstr(bh) != qstr(eq)) begin
            errors++;
            $display("FAIL mode0_wrap_half got=[%s] exp=[%s]", qstr(bh), qstr(eq));
        end
    endtask

    task automatic test_five_step();
        int eq[$];
        restart_small();
        run_small(10);
        sif.r4017_wr   = 1'b1;
        sif.r4017_data = 8'h80;
        run_small(1);
        sif.r4017_wr   = 1'b0;
        sif.r4017_data = 8'h00;
        checks++;
        if ({sif.quarter_frame, sif.half_frame} !== 2'b11) begin
            errors++;
            $display("FAIL write_pulse got=%b exp=11", {sif.quarter_frame, sif.half_frame});
        end
        run_small(141 - scyc);
        // Even-phase write at edge 11: counter forced to 0 at edge 14.
        eq = '{11, 14 + SS1 + 1, 14 + SS2 + 1, 14 + SS3 + 1, 14 + SS5 + 1, 14 + SS5 + 2 + SS1 + 1};
        checks++;
        if (qstr(sq) != qstr(eq)) begin
            errors++;
            $display("FAIL five_step_quarter got=[%s] exp=[%s]", qstr(sq), qstr(eq));
        end
        eq = '{11, 14 + SS2 + 1, 14 + SS5 + 1};
        checks++;
        if (qstr(sh) != qstr(eq)) begin
            errors++;
            $display("FAIL five_step_half got=[%s] exp=[%s]", qstr(sh), qstr(eq));
        end
        checks++;
        if (s_irq_hi != 0) begin
            errors++;
            $display("FAIL five_step_irq got=%0d exp=0", s_irq_hi);
        end
        checks++;
        if (sif.apu_tick !== 1'b1) begin
            errors++;
            $display("FAIL odd_phase_setup got=%b exp=1", sif.apu_tick);
        end
        sq.delete();
        sif.r4017_wr   = 1'b1;
        sif.r4017_data = 8'h80;
        run_small(1);
        sif.r4017_wr   = 1'b0;
        sif.r4017_data = 8'h00;
        run_small(142 + 4 + SS1 + 1 - scyc);
        eq = '{142, 146 + SS1 + 1};
        checks++;
        if (qstr(sq) != qstr(eq)) begin
            errors++;
            $display("FAIL odd_phase_delay got=[%s] exp=[%s]", qstr(sq), qstr(eq));
        end
    endtask

    task automatic test_irq_inhibit();
        int eq[$];
        restart_small();
        run_small(SS4);
        checks++;
        if (sif.frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL inhibit_setup_irq got=%b exp=1", sif.frame_irq);
        end
        sif.r4017_wr   = 1'b1;
        sif.r4017_data = 8'h40;
        run_small(1);
        sif.r4017_wr   = 1'b0;
        sif.r4017_data = 8'h00;
        checks++;
        if (sif.frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_clear got=%b exp=0", sif.frame_irq);
        end
        sq.delete();
        s_irq_hi = 0;
        run_small(260 - scyc);
        checks++;
        if (s_irq_hi != 0) begin
            errors++;
            $display("FAIL inhibit_block got=%0d exp=0", s_irq_hi);
        end
        // Odd-phase write at edge 84 forces 0 at edge 88; wrap again at 173.
        eq = '{88 + SS1 + 1, 88 + SS2 + 1, 88 + SS3 + 1, 88 + SS4 + 1,
               173 + SS1 + 1, 173 + SS2 + 1, 173 + SS3 + 1, 173 + SS4 + 1};
        checks++;
        if (qstr(sq) != qstr(eq)) begin
            errors++;
            $display("FAIL inhibit_quarter got=[%s] exp=[%s]", qstr(sq), qstr(eq));
        end
    endtask

    task automatic test_back_to_back();
        int eq[$];
        restart_small();
        run_small(10);
        sif.r4017_wr   = 1'b1;
        sif.r4017_data = 8'h00;
        run_small(1);
        sif.r4017_wr   = 1'b0;
        run_small(1);
        sif.r4017_wr   = 1'b1;
        run_small(1);
        sif.r4017_wr   = 1'b0;
        run_small(40 - scyc);
        eq = '{13 + 3 + SS1 + 1};
        checks++;
        if (qstr(sq) != qstr(eq)) begin
            errors++;
            $display("FAIL back_to_back got=[%s] exp=[%s]", qstr(sq), qstr(eq));
        end
    endtask

    task automatic test_mid_reset();
        int eq[$];
        restart_small();
        run_small(SS4);
        sif.r4017_wr   = 1'b1;
        sif.r4017_data = 8'h80;
        run_small(1);
        sif.r4017_wr   = 1'b0;
        sif.r4017_data = 8'h00;
        checks++;
        if ({sif.quarter_frame, sif.half_frame, sif.frame_irq} !== 3'b111) begin
            errors++;
            $display("FAIL mid_reset_setup got=%b exp=111",
                     {sif.quarter_frame, sif.half_frame, sif.frame_irq});
        end
        #1;
        rst_s_n = 1'b0;
        #1;
        checks++;
        if ({sif.apu_tick, sif.quarter_frame, sif.half_frame, sif.frame_irq} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%b exp=0000",
                     {sif.apu_tick, sif.quarter_frame, sif.half_frame, sif.frame_irq});
        end
        tick();
        rst_s_n = 1'b1;
        scyc = 0;
        sq.delete();
        sh.delete();
        run_small(SS4 + 1);
        eq = '{SS1 + 1, SS2 + 1, SS3 + 1, SS4 + 1};
        checks++;
        if (qstr(sq) != qstr(eq)) begin
            errors++;
            $display("FAIL mid_reset_restart got=[%s] exp=[%s]", qstr(sq), qstr(eq));
        end
        checks++;
        if (sif.frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_mode0_irq got=%b exp=1", sif.frame_irq);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        rst_s_n        = 1'b0;
        bif.r4017_wr   = 1'b0;
        bif.r4017_data = 8'h00;
        bif.r4015_rd   = 1'b0;
        sif.r4017_wr   = 1'b0;
        sif.r4017_data = 8'h00;
        sif.r4015_rd   = 1'b0;
        b_irq_first    = -1;
        s_irq_hi       = 0;
        test_reset();
        test_mode0_sequence();
        test_irq_read();
        test_five_step();
        test_irq_inhibit();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
